// File: rtl/serial_pattern_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : serial_pattern_ctrl
//  Purpose  : Control stage for a 10-bit parallel-load, LSB-first serial
//             shifter. Picks one of eight fixed patterns, loads it into the
//             shifter, then paces WIDTH shift strobes one every TICK_DIV
//             clocks and pulses done at the end of the message.
//  Ports    : clk_i        - system clock, rising edge
//             reset_i      - synchronous active-high reset
//             start_i      - message request, honoured only while idle
//             sel_i[2:0]   - pattern index, captured with the accepted start
//             load_o       - pattern word for the shifter's parallel input
//             par_load_o   - one-cycle parallel-load strobe
//             enable_o     - one-cycle shift strobe
//             busy_o       - high while a message is in progress
//             done_o       - one-cycle pulse at message end
//  Revision : 1.0 - initial release
// ============================================================================
module serial_pattern_ctrl #(
  parameter int WIDTH    = 10,
  parameter int TICK_DIV = 25000000
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [2:0]       sel_i,
  output logic [WIDTH-1:0] load_o,
  output logic             par_load_o,
  output logic             enable_o,
  output logic             busy_o,
  output logic             done_o
);

  // A divider of 1 still needs a one-bit counter so the compare is legal.
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  load_q, load_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [3:0]        bit_q, bit_d;
  logic              par_load_q, par_load_d;
  logic              enable_q, enable_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Pattern table; bit 0 leaves the shifter first.
  function automatic logic [9:0] pattern(input logic [2:0] idx);
    logic [9:0] p;
    case (idx)
      3'd0:    p = 10'h01D;  // A
      3'd1:    p = 10'h157;  // B
      3'd2:    p = 10'h005;  // I
      3'd3:    p = 10'h001;  // E
      3'd4:    p = 10'h007;  // T
      3'd5:    p = 10'h015;  // S
      3'd6:    p = 10'h077;  // M
      default: p = 10'h3FF;  // test
    endcase
    return p;
  endfunction

  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    tick_d  = tick_q;
    bit_d   = bit_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_LOAD;
          load_d  = WIDTH'(pattern(sel_i));
        end
      end
      ST_LOAD: begin
        state_d = ST_SHIFT;
        tick_d  = '0;
        bit_d   = '0;
      end
      ST_SHIFT: begin
        if (tick_q == TICK_LAST) begin
          // This cycle carries a shift strobe.
          tick_d = '0;
          bit_d  = bit_q + 4'd1;
          if (bit_q == BIT_LAST) begin
            state_d = ST_DONE;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from the next state and
    // next tick count; they then line up with the state they describe.
    par_load_d = (state_d == ST_LOAD);
    enable_d   = (state_d == ST_SHIFT) && (tick_d == TICK_LAST);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      load_q     <= '0;
      tick_q     <= '0;
      bit_q      <= '0;
      par_load_q <= 1'b0;
      enable_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_q     <= load_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      par_load_q <= par_load_d;
      enable_q   <= enable_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign load_o     = load_q;
  assign par_load_o = par_load_q;
  assign enable_o   = enable_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule
`default_nettype wire

// File: doc/serial_pattern_ctrl.md
Name: serial_pattern_ctrl

Overview:
- Control stage directly upstream of the 10-bit parallel-load, LSB-first serial shifter.
- Selects one of eight fixed 10-bit patterns and drives the shifter's parallel data, parallel-load strobe and shift-enable strobe.
- Paces one shift per TICK_DIV clock cycles, counts exactly WIDTH shifts, then reports completion.
- Typical use: a Morse-style blinker on a board LED (dot = 1, dash = 111, gap = 0).

Parameters:
- WIDTH, 10, pattern width and number of shifts per message; fixed at 10 for this pattern table.
- TICK_DIV, 25000000, clock cycles per shift (0.5 s at 50 MHz); legal range >= 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to send a message; level-sampled, acted on only in IDLE.
- sel  input  3  pattern index; captured on the accepting start.
- load  output  WIDTH  pattern word to the shifter's parallel input.
- par_load  output  1  one-cycle strobe: shifter loads `load`.
- enable  output  1  one-cycle strobe: shifter shifts one bit.
- busy  output  1  high while a message is in progress.
- done  output  1  one-cycle pulse at message end.

Behaviour:
- One clock; reset is synchronous and active-high.
- All outputs are registered.
- Reset (any state, including mid-message) clears everything on the next edge:
  - state = IDLE; load = 0; par_load = enable = busy = done = 0.
  - tick counter = 0; bit counter = 0.
- Pattern table (index: value; LSB is shifted out first):
  - 0: 0x01D (A)
  - 1: 0x157 (B)
  - 2: 0x005 (I)
  - 3: 0x001 (E)
  - 4: 0x007 (T)
  - 5: 0x015 (S)
  - 6: 0x077 (M)
  - 7: 0x3FF (test)
- State IDLE:
  - busy = 0.
  - On an edge with start = 1, latch table[sel] into `load` and go to LOAD.
- State LOAD (exactly 1 cycle):
  - par_load = 1, busy = 1.
  - Clear tick and bit counters; go to SHIFT.
- State SHIFT:
  - Tick counter runs 0 .. TICK_DIV-1, then wraps.
  - enable = 1 for the single cycle in which the counter equals TICK_DIV-1; the bit counter increments on that cycle.
  - The first enable occurs TICK_DIV cycles after the par_load cycle; subsequent enables are spaced exactly TICK_DIV cycles apart.
  - After the WIDTH-th enable, go to DONE.
- State DONE (exactly 1 cycle):
  - done = 1, busy = 1; then go to IDLE.
- Latency from start:
  - start sampled at edge k -> par_load high in cycle k+1.
  - Last enable in cycle k+1+WIDTH*TICK_DIV.
  - done in cycle k+2+WIDTH*TICK_DIV.
  - busy low again in cycle k+3+WIDTH*TICK_DIV.
- start/sel handling:
  - start while busy is ignored.
  - sel changes after acceptance are ignored; `load` stays stable for the whole message and holds its value in IDLE until the next accepted start.
  - start held high continuously: a new message is accepted on the first IDLE cycle after done, giving back-to-back messages one idle cycle apart.
- Invariants:
  - par_load and enable are never high in the same cycle.
  - Exactly WIDTH enables per par_load.
- TICK_DIV = 1: enable is high for WIDTH consecutive cycles immediately after par_load.
- Counter widths:
  - Tick counter: $clog2(TICK_DIV) bits, minimum 1.
  - Bit counter: 4 bits.
  - No overflow is possible within legal parameters.

Test Plan:
- Reset, TICK_DIV=4: assert reset for 2 cycles -> all outputs 0, busy 0. Then start=1, sel=0 for one cycle (edge k) -> load = 0x01D; par_load high only in cycle k+1; enables in cycles k+5, k+9, ..., k+41 (10 total); done in cycle k+42; busy high in cycles k+1 to k+42.
- Shifter co-simulation, sel=1, TICK_DIV=4: the connected shifter's serial output samples across the 10 shifts read 1,1,1,0,1,0,1,0,1,0 (B pattern, LSB first).
- Ignore while busy: start pulsed at cycle k+10 with sel=7 during a sel=3 message -> no new par_load; load stays 0x001; exactly 10 enables.
- Reset mid-message: reset=1 at the 5th enable cycle -> next edge: state IDLE, all outputs 0, no further enables. A later start with sel=4 sends a full 0x007 message normally.
- Continuous start, sel=6, TICK_DIV=1: par_load, then 10 consecutive enable cycles, done, one IDLE cycle, then par_load again. load = 0x077 throughout; par_load and enable never overlap.
